// File: rtl/ndc_to_screen.sv
// Viewport stage: fp32 NDC (x,y,z) -> screen pixel (px,py) and unsigned depth.
// Define NDC_CLIP_FLAG_EN to drive 'clipped' from the per-coordinate out-of-range flags.
module ndc_to_screen #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int DEPTH_BITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 x,
  input  logic [31:0]                 y,
  input  logic [31:0]                 z,
  output logic                        busy,
  output logic [$clog2(SCREEN_W)-1:0] px,
  output logic [$clog2(SCREEN_H)-1:0] py,
  output logic [DEPTH_BITS-1:0]       depth,
  output logic                        clipped,
  output logic                        done
);
  localparam int PXW = $clog2(SCREEN_W);
  localparam int PYW = $clog2(SCREEN_H);
  localparam int MW0 = (PXW > PYW) ? PXW : PYW;
  localparam int MW  = (MW0 > DEPTH_BITS) ? MW0 : DEPTH_BITS;
  localparam int PW  = 19 + MW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONV_X = 3'd1;
  localparam logic [2:0] S_CONV_Y = 3'd2;
  localparam logic [2:0] S_CONV_Z = 3'd3;
  localparam logic [2:0] S_MAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Returns {out_of_range, q[17:0]} with q in signed Q2.16, clamped to [-1.0, +1.0].
  function automatic logic [18:0] fp_to_q(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  sh;
    logic [16:0] mag;
    logic        oor;
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    sh  = 8'd0;
    mag = '0;
    oor = 1'b0;
    if (e == 8'd0) begin
      mag = '0;
    end else if (e == 8'hff && f[22:0] != 23'd0) begin
      oor = 1'b1;
    end else if (e >= 8'd128) begin
      mag = 17'h1ffff;
      oor = 1'b1;
    end else begin
      // value*2^16 = m * 2^(e-134); e<=127 so this is always a right shift
      sh  = 8'd134 - e;
      mag = 17'(m >> sh);
    end
    if (mag > 17'd65536) begin
      mag = 17'd65536;
      oor = 1'b1;
    end
    return {oor, f[31] ? -{1'b0, mag} : {1'b0, mag}};
  endfunction

  logic [2:0]            state_q, state_d;
  logic [31:0]           xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
  logic [17:0]           qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
  logic [PXW-1:0]        mpx_q, mpx_d, px_q, px_d;
  logic [PYW-1:0]        mpy_q, mpy_d, py_q, py_d;
  logic [DEPTH_BITS-1:0] mdep_q, mdep_d, depth_q, depth_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [18:0]           cv;
  logic [17:0]           ux, uy, uz;
  logic [PW-1:0]         prod_x, prod_y, prod_z, sx, sy;

  assign cv = fp_to_q((state_q == S_CONV_X) ? xr_q : (state_q == S_CONV_Y) ? yr_q : zr_q);

  // Offsets are taken modulo 2^18; clamped q keeps them within [0, 2^17].
  assign ux     = qx_q + 18'd65536;
  assign uy     = 18'd65536 - qy_q;
  assign uz     = qz_q + 18'd65536;
  assign prod_x = PW'(ux) * PW'(SCREEN_W);
  assign prod_y = PW'(uy) * PW'(SCREEN_H);
  assign prod_z = PW'(uz) * PW'((2 ** DEPTH_BITS) - 1);
  assign sx     = prod_x >> 17;
  assign sy     = prod_y >> 17;

`ifdef NDC_CLIP_FLAG_EN
  logic oor_q, oor_d, clipped_q, clipped_d;
  assign clipped = clipped_q;
`else
  logic unused_oor;
  assign unused_oor = cv[18];
  assign clipped    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    zr_d    = zr_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    qz_d    = qz_q;
    mpx_d   = mpx_q;
    mpy_d   = mpy_q;
    mdep_d  = mdep_q;
    px_d    = px_q;
    py_d    = py_q;
    depth_d = depth_q;
    busy_d  = (state_q != S_IDLE) || start;
    done_d  = (state_q == S_DONE);
`ifdef NDC_CLIP_FLAG_EN
    oor_d     = oor_q;
    clipped_d = clipped_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        xr_d    = x;
        yr_d    = y;
        zr_d    = z;
        state_d = S_CONV_X;
      end
      S_CONV_X: begin
        qx_d    = cv[17:0];
        state_d = S_CONV_Y;
`ifdef NDC_CLIP_FLAG_EN
        oor_d   = cv[18];
`endif
      end
      S_CONV_Y: begin
        qy_d    = cv[17:0];
        state_d = S_CONV_Z;
`ifdef NDC_CLIP_FLAG_EN
        oor_d   = oor_q | cv[18];
`endif
      end
      S_CONV_Z: begin
        qz_d    = cv[17:0];
        state_d = S_MAP;
`ifdef NDC_CLIP_FLAG_EN
        oor_d   = oor_q | cv[18];
`endif
      end
      S_MAP: begin
        mpx_d   = (sx > PW'(SCREEN_W - 1)) ? PXW'(SCREEN_W - 1) : sx[PXW-1:0];
        mpy_d   = (sy > PW'(SCREEN_H - 1)) ? PYW'(SCREEN_H - 1) : sy[PYW-1:0];
        mdep_d  = DEPTH_BITS'(prod_z >> 17);
        state_d = S_DONE;
      end
      S_DONE: begin
        px_d    = mpx_q;
        py_d    = mpy_q;
        depth_d = mdep_q;
        state_d = S_IDLE;
`ifdef NDC_CLIP_FLAG_EN
        clipped_d = oor_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      zr_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      qz_q    <= '0;
      mpx_q   <= '0;
      mpy_q   <= '0;
      mdep_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      depth_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NDC_CLIP_FLAG_EN
      oor_q     <= 1'b0;
      clipped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      zr_q    <= zr_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qz_q    <= qz_d;
      mpx_q   <= mpx_d;
      mpy_q   <= mpy_d;
      mdep_q  <= mdep_d;
      px_q    <= px_d;
      py_q    <= py_d;
      depth_q <= depth_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NDC_CLIP_FLAG_EN
      oor_q     <= oor_d;
      clipped_q <= clipped_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign px    = px_q;
  assign py    = py_q;
  assign depth = depth_q;
endmodule

// File: tb/tb_ndc_to_screen.sv
// Directed + randomized bench for ndc_to_screen against a real-arithmetic viewport model.
module tb_ndc_to_screen;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   x = '0, y = '0, z = '0;
  logic          busy, clipped, done;
  logic [9:0]    px;
  logic [8:0]    py;
  logic [DB-1:0] depth;

  int checks = 0;
  int errors = 0;

  ndc_to_screen #(.SCREEN_W(W), .SCREEN_H(H), .DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .z(z),
    .busy(busy), .px(px), .py(py), .depth(depth), .clipped(clipped), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // NDC value as a real number, scaled to 2^16 units, truncated and clamped to +-1.0.
  task automatic model_q(input logic [31:0] f, output longint q, output bit oor);
    int     e;
    real    v;
    longint mag;
    e   = int'(f[30:23]);
    oor = 1'b0;
    mag = 0;
    if (e == 0) mag = 0;
    else if (e == 255 && f[22:0] != 0) oor = 1'b1;
    else begin
      v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
      if (e == 255 || v >= 2.0) begin mag = 131071; oor = 1'b1; end
      else mag = longint'($rtoi(v * 65536.0));
    end
    if (mag > 65536) begin mag = 65536; oor = 1'b1; end
    q = f[31] ? -mag : mag;
  endtask

  task automatic expect_vertex(input logic [31:0] vx, vy, vz,
                               output longint epx, epy, edep, output bit eclip);
    longint qx, qy, qz;
    bit     ox, oy, oz;
    model_q(vx, qx, ox);
    model_q(vy, qy, oy);
    model_q(vz, qz, oz);
    epx  = ((qx + 65536) * W) / 131072;
    if (epx > W - 1) epx = W - 1;
    epy  = ((65536 - qy) * H) / 131072;
    if (epy > H - 1) epy = H - 1;
    edep = ((qz + 65536) * ((64'd1 << DB) - 1)) / 131072;
`ifdef NDC_CLIP_FLAG_EN
    eclip = ox | oy | oz;
`else
    eclip = 1'b0;
`endif
  endtask

  // Caller is positioned just after an edge; the next edge is the capture edge N.
  // Returns just after edge N+5 with outputs checked.
  task automatic do_vertex(input logic [31:0] vx, vy, vz, input bit repulse);
    longint epx, epy, edep;
    bit     eclip;
    expect_vertex(vx, vy, vz, epx, epy, edep, eclip);
    x = vx; y = vy; z = vz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = $urandom; z = $urandom;
    for (int k = 1; k <= 4; k++) begin
      if (repulse && k == 1) start = 1'b1;
      @(posedge clk); #1;
      if (repulse && k == 1) start = 1'b0;
      chk("busy_mid", busy, 1);
      chk("done_early", done, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("px", px, epx);
    chk("py", py, epy);
    chk("depth", depth, edep);
    chk("clipped", clipped, eclip);
  endtask

  function automatic logic [31:0] rnd_f();
    logic [31:0] sp [9];
    sp = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000, 32'h7fc00000,
           32'h00000001, 32'h3f800000, 32'hbf800000, 32'h40000000};
    if ($urandom_range(0, 5) == 0) return sp[$urandom_range(0, 8)];
    return {1'($urandom), 8'($urandom_range(110, 128)), 23'($urandom)};
  endfunction

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    chk("rst_depth", depth, 0);
    chk("rst_clipped", clipped, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_vertex(32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    do_vertex(32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0);
    @(posedge clk); #1;
    do_vertex(32'hbf800000, 32'hbf800000, 32'hbf800000, 1'b0);
    @(posedge clk); #1;
    do_vertex(32'h3f000000, 32'hbf000000, 32'h00000000, 1'b0);
    @(posedge clk); #1;
    do_vertex(32'h40000000, 32'h7fc00000, 32'hff800000, 1'b0);
    @(posedge clk); #1;

    // re-pulsed start mid-conversion, then back-to-back
    do_vertex(32'h3e800000, 32'hbe800000, 32'h3f400000, 1'b1);
    chk("done_single", done, 1);
    do_vertex(32'hbf400000, 32'h3dcccccd, 32'hbe4ccccd, 1'b0);
    @(posedge clk); #1;
    chk("done_b2b_clear", done, 0);

    // asynchronous reset mid-conversion
    x = 32'h3f800000; y = 32'h3f800000; z = 32'h3f800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_px", px, 0);
    chk("arst_py", py, 0);
    chk("arst_depth", depth, 0);
    chk("arst_clipped", clipped, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", done, 0);
    end
    // start held high across reset release
    reset = 1'b1;
    @(posedge clk); #1;
    x = 32'h3f000000; y = 32'h3f000000; z = 32'hbf000000; start = 1'b1;
    reset = 1'b0;
    do_vertex(32'h3f000000, 32'h3f000000, 32'hbf000000, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      do_vertex(rnd_f(), rnd_f(), rnd_f(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("busy_gap", busy, 0);
      end
    end
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
